// File: rtl/scan_addr_gen_if.sv
// Control/status bundle between a scan controller and scan_addr_gen.
// The controller side drives start/stop/config; the generator drives A/OE/status.
interface scan_addr_gen_if #(
  parameter int DIV_W = 8
);
  logic             start;
  logic             stop;
  logic [1:0]       mode;
  logic             oneshot;
  logic [DIV_W-1:0] div;
  logic [2:0]       A;
  logic             OE;
  logic             busy;
  logic             done;

  modport master (
    output start, stop, mode, oneshot, div,
    input  A, OE, busy, done
  );

  modport slave (
    input  start, stop, mode, oneshot, div,
    output A, OE, busy, done
  );
endinterface

// File: rtl/scan_addr_gen.sv
// 3-bit scan address/enable generator feeding a 3-to-8 select decoder.
// Up, down or ping-pong walk with programmable per-address dwell.
module scan_addr_gen #(
  parameter int DIV_W = 8
) (
  input logic           clk,
  input logic           rst,
  scan_addr_gen_if.slave bus
);

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  state_t           state_q, state_n;
  logic [2:0]       a_q, a_n;
  logic             oe_q, oe_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;
  logic             dir_q, dir_n;
  logic [DIV_W-1:0] cnt_q, cnt_n;
  logic [DIV_W-1:0] div_q, div_n;
  logic [1:0]       mode_q, mode_n;
  logic             os_q, os_n;
  logic             fin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= 3'd0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      div_q   <= '0;
      mode_q  <= 2'b00;
      os_q    <= 1'b0;
    end else begin
      state_q <= state_n;
      a_q     <= a_n;
      oe_q    <= oe_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      dir_q   <= dir_n;
      cnt_q   <= cnt_n;
      div_q   <= div_n;
      mode_q  <= mode_n;
      os_q    <= os_n;
    end
  end

  always_comb begin
    state_n = state_q;
    a_n     = a_q;
    oe_n    = oe_q;
    busy_n  = busy_q;
    done_n  = 1'b0;
    dir_n   = dir_q;
    cnt_n   = cnt_q;
    div_n   = div_q;
    mode_n  = mode_q;
    os_n    = os_q;
    fin     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!bus.stop && bus.start) begin
          mode_n  = bus.mode;
          os_n    = bus.oneshot;
          div_n   = bus.div;
          a_n     = (bus.mode == 2'b01) ? 3'd7 : 3'd0;
          dir_n   = 1'b0;
          cnt_n   = '0;
          state_n = SCAN;
          oe_n    = 1'b1;
          busy_n  = 1'b1;
        end
      end
      SCAN: begin
        if (bus.stop) begin
          state_n = IDLE;
          oe_n    = 1'b0;
          busy_n  = 1'b0;
        end else if (cnt_q != div_q) begin
          cnt_n = cnt_q + DIV_W'(1);
        end else begin
          cnt_n = '0;
          // Ping-pong turns at the ends so no endpoint is visited twice
          unique case (1'b1)
            (mode_q == 2'b01): begin
              if (a_q == 3'd0) begin
                if (os_q) fin = 1'b1;
                else      a_n = 3'd7;
              end else begin
                a_n = a_q - 3'd1;
              end
            end
            (mode_q == 2'b10): begin
              if (!dir_q) begin
                if (a_q == 3'd7) begin
                  dir_n = 1'b1;
                  a_n   = 3'd6;
                end else begin
                  a_n = a_q + 3'd1;
                end
              end else if (a_q == 3'd0) begin
                if (os_q) begin
                  fin = 1'b1;
                end else begin
                  dir_n = 1'b0;
                  a_n   = 3'd1;
                end
              end else begin
                a_n = a_q - 3'd1;
              end
            end
            default: begin
              if (a_q == 3'd7) begin
                if (os_q) fin = 1'b1;
                else      a_n = 3'd0;
              end else begin
                a_n = a_q + 3'd1;
              end
            end
          endcase
          if (fin) begin
            state_n = IDLE;
            oe_n    = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.A    = a_q;
  assign bus.OE   = oe_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_scan_addr_gen.sv
// Directed bench for scan_addr_gen: vector table plus
// hand-written multi-cycle sequences.
module tb_scan_addr_gen;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  scan_addr_gen_if #(.DIV_W(8)) bus ();

  scan_addr_gen #(.DIV_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       stop;
    logic [1:0] mode;
    logic       oneshot;
    logic [7:0] div;
    logic [2:0] a;
    logic       oe;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vt[12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [7:0] got, logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_all(string tag, logic [2:0] a, logic oe,
                         logic busy, logic done);
    chk({tag, " A"}, 8'(bus.A), 8'(a));
    chk({tag, " OE"}, 8'(bus.OE), 8'(oe));
    chk({tag, " busy"}, 8'(bus.busy), 8'(busy));
    chk({tag, " done"}, 8'(bus.done), 8'(done));
  endtask

  task automatic drive(logic st, logic sp, logic [1:0] m,
                       logic os, logic [7:0] d);
    bus.start   = st;
    bus.stop    = sp;
    bus.mode    = m;
    bus.oneshot = os;
    bus.div     = d;
  endtask

  function automatic logic [2:0] pp(int i);
    int j;
    j = i % 14;
    return (j <= 7) ? 3'(j) : 3'(14 - j);
  endfunction

  initial begin
    errors = 0;
    checks = 0;

    // oneshot up, div=0, then start+stop together in IDLE
    vt[0] = '{1, 0, 2'b00, 1, 8'd0, 3'd0, 1, 1, 0};
    for (int i = 1; i < 8; i++)
      vt[i] = '{0, 0, 2'b00, 1, 8'd0, 3'(i), 1, 1, 0};
    vt[8]  = '{0, 0, 2'b00, 1, 8'd0, 3'd7, 0, 0, 1};
    vt[9]  = '{0, 0, 2'b00, 1, 8'd0, 3'd7, 0, 0, 0};
    vt[10] = '{1, 1, 2'b00, 1, 8'd0, 3'd7, 0, 0, 0};
    vt[11] = '{0, 0, 2'b00, 1, 8'd0, 3'd7, 0, 0, 0};

    rst = 1'b1;
    drive(0, 0, 2'b00, 0, 8'd0);
    #2;
    chk_all("reset", 3'd0, 0, 0, 0);
    step();
    step();
    rst = 1'b0;
    step();
    chk_all("post_reset", 3'd0, 0, 0, 0);

    for (int i = 0; i < 12; i++) begin
      drive(vt[i].start, vt[i].stop, vt[i].mode, vt[i].oneshot, vt[i].div);
      step();
      chk_all($sformatf("vec%0d", i), vt[i].a, vt[i].oe,
              vt[i].busy, vt[i].done);
    end

    // oneshot down, div=2: each address held 3 cycles
    drive(1, 0, 2'b01, 1, 8'd2);
    for (int i = 0; i < 24; i++) begin
      step();
      bus.start = 1'b0;
      chk_all($sformatf("down%0d", i), 3'(7 - i / 3), 1, 1, 0);
    end
    step();
    chk_all("down_fin", 3'd0, 0, 0, 1);
    step();
    chk_all("down_after", 3'd0, 0, 0, 0);

    // oneshot ping-pong, div=0
    drive(1, 0, 2'b10, 1, 8'd0);
    for (int i = 0; i < 15; i++) begin
      step();
      bus.start = 1'b0;
      chk_all($sformatf("pp1_%0d", i), pp(i), 1, 1, 0);
    end
    step();
    chk_all("pp1_fin", 3'd0, 0, 0, 1);
    step();
    chk_all("pp1_after", 3'd0, 0, 0, 0);

    // continuous ping-pong, then stop
    drive(1, 0, 2'b10, 0, 8'd0);
    for (int i = 0; i < 20; i++) begin
      step();
      bus.start = 1'b0;
      chk_all($sformatf("pp2_%0d", i), pp(i), 1, 1, 0);
    end
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk_all("pp2_stop", 3'd5, 0, 0, 0);

    // continuous up, div=1, wrap; input changes mid-scan ignored
    drive(1, 0, 2'b00, 0, 8'd1);
    for (int i = 0; i < 20; i++) begin
      step();
      bus.start = (i == 3);
      if (i == 3) begin
        bus.mode    = 2'b01;
        bus.div     = 8'd5;
        bus.oneshot = 1'b1;
      end
      chk_all($sformatf("up2_%0d", i), 3'((i / 2) % 8), 1, 1, 0);
    end
    drive(0, 1, 2'b00, 0, 8'd1);
    step();
    bus.stop = 1'b0;
    chk_all("up2_stop", 3'd1, 0, 0, 0);
    step();
    chk_all("up2_idle", 3'd1, 0, 0, 0);

    // mode 11 walks like up
    drive(1, 0, 2'b11, 1, 8'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      bus.start = 1'b0;
      chk_all($sformatf("m11_%0d", i), 3'(i), 1, 1, 0);
    end
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk_all("m11_stop", 3'd2, 0, 0, 0);

    // async reset mid-dwell at A=5, then fresh down start
    drive(1, 0, 2'b00, 0, 8'd3);
    for (int i = 0; i < 22; i++) begin
      step();
      bus.start = 1'b0;
    end
    chk_all("pre_rst", 3'd5, 1, 1, 0);
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 3'd0, 0, 0, 0);
    step();
    rst = 1'b0;
    step();
    chk_all("rst_idle", 3'd0, 0, 0, 0);
    drive(1, 0, 2'b01, 1, 8'd0);
    step();
    bus.start = 1'b0;
    chk_all("restart0", 3'd7, 1, 1, 0);
    step();
    chk_all("restart1", 3'd6, 1, 1, 0);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk_all("restart_stop", 3'd6, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
